fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Program counter and fetch controller for the CPU core. Drives the 5-bit address of the combinational program_memory and registers the returned 16-bit instruction. Presents the instruction to decode over a valid/ready handshake and handles branch redirects, the HALT instruction and restart. Sits between program_memory and the decode/execute stage.

Parameters:
ADDR_W, 5, program memory address width (32 words)
INSTR_W, 16, instruction width
RESET_PC, 0, PC value loaded on reset and on start
HALT_OP, 5'b11111, opcode (instr[15:11]) that stops fetching
CNT_W, 8, width of the retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin or restart fetching from RESET_PC
pm_addr  output  ADDR_W  address to program_memory
pm_data  input  INSTR_W  combinational instruction from program_memory
instr  output  INSTR_W  registered instruction to decode
instr_valid  output  1  instr holds a valid instruction
instr_ready  input  1  decode accepts instr this cycle
redirect_valid  input  1  branch/jump taken
redirect_addr  input  ADDR_W  branch/jump target
pc  output  ADDR_W  current program counter
halted  output  1  HALT instruction accepted; fetch stopped
retired_cnt  output  CNT_W  count of accepted instructions, saturating

Behaviour:
- One clock; asynchronous active-low reset. Reset gives state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, halted=0, retired_cnt=0. Reset that occurs mid-fetch or mid-handshake discards the pending instruction immediately.
- pm_addr = pc (combinational) in every state.
- The state machine has four states: IDLE, FETCH, ISSUE, HALT.
- IDLE: no outputs are valid. On start, go to FETCH with pc=RESET_PC. redirect_valid is ignored.
- FETCH: at the clock edge, instr<=pm_data, instr_valid<=1, then go to ISSUE. If redirect_valid is asserted, pc<=redirect_addr, no capture happens, and the state stays FETCH.
- ISSUE: instr_valid=1 and instr is held stable until it is accepted.
  - Transfer happens when instr_valid && instr_ready at a rising edge.
  - redirect_valid has priority over the transfer. It drops instr (instr_valid<=0, no retire), sets pc<=redirect_addr and goes to FETCH.
  - On a transfer with opcode != HALT_OP: pc<=pc+1, retired_cnt increments, instr_valid<=0, go to FETCH.
  - On a transfer with opcode == HALT_OP: retired_cnt increments, instr_valid<=0, halted<=1, pc is held, go to HALT.
- HALT: halted=1 and no fetching. redirect_valid is ignored. On start: halted<=0, pc<=RESET_PC, go to FETCH. retired_cnt is not cleared.
- start is ignored in FETCH and ISSUE.
- PC arithmetic is modulo 2^ADDR_W: 31+1 wraps to 0 with no flag.
- retired_cnt saturates at 2^CNT_W-1.
- Latency: 1 cycle from entering FETCH to instr_valid. Peak throughput is 1 instruction per 2 cycles.

Decomposition:
- Shared package cpu_pkg holds:
  - ADDR_W, INSTR_W, OPCODE_W=5
  - opcode field position [15:11]
  - HALT_OP
  - fetch_state_t enum {IDLE, FETCH, ISSUE, HALT}
- No sub-module is needed; the PC, state register and counter live in this module.
- program_memory is instantiated beside this block at core level, not inside it.

Test Plan:
The bench pairs this block with program_memory, preloaded with:
- addr0=16'b00001_010_000_00001
- addr1=16'b00001_011_001_00010
- addr2=16'b11111_000_000_00000 (HALT)
- addr31=0

Scenarios:
- Reset then start pulse, instr_ready=1 -> instr sequence 0x0A01, 0x0B22, 0xF800. halted=1 after the third transfer, pc=2, retired_cnt=3.
- instr_ready=0 for 5 cycles in ISSUE -> instr stays 0x0A01 with instr_valid=1 throughout, pc=0, retired_cnt=0.
- In ISSUE at pc=0, redirect_valid=1 with redirect_addr=31 -> the instruction is dropped (retired_cnt unchanged), next instr=0x0000 from addr31. Accepting it gives pc=0 (wrap).
- HALT state, then redirect_valid=1 -> no change. Then start -> halted=0, instr=0x0A01 again, retired_cnt continues from 3.
- reset_n low mid-ISSUE, with no clock edge -> instr_valid=0, instr=0, pc=0, halted=0 immediately. No fetch occurs until start.
- Force retired_cnt=255, then accept an instruction -> retired_cnt stays 255.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: field widths, opcode field position and the
// fetch state encoding used by the fetch sequencer.
package cpu_pkg;

  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned OPCODE_W  = 5;
  localparam int unsigned OPCODE_HI = 15;
  localparam int unsigned OPCODE_LO = 11;

  localparam logic [OPCODE_W-1:0] HALT_OP = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: addresses program_memory, registers the
// returned instruction and hands it to decode over a valid/ready handshake.
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned          ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned          INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter logic [OPCODE_W-1:0]  HALT_OP  = cpu_pkg::HALT_OP,
  parameter int unsigned          CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  pm_addr,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic [CNT_W-1:0]   retired_cnt
);

  fetch_state_t        state;
  logic [OPCODE_W-1:0] opcode;
  logic                is_halt;

  assign pm_addr = pc;
  assign opcode  = instr[OPCODE_HI:OPCODE_LO];
  assign is_halt = (opcode == HALT_OP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pc    <= RESET_PC;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (redirect_valid) begin
            pc <= redirect_addr;
          end else begin
            instr       <= pm_data;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          // A taken branch squashes the held instruction even if decode is ready.
          if (redirect_valid) begin
            instr_valid <= 1'b0;
            pc          <= redirect_addr;
            state       <= FETCH;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            if (retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
            if (is_halt) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              pc    <= pc + 1'b1;
              state <= FETCH;
            end
          end
        end
        HALT: begin
          if (start) begin
            halted <= 1'b0;
            pc     <= RESET_PC;
            state  <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized handshake and
// redirect traffic checked against a transaction-level reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  pm_addr;
  logic [15:0] pm_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [4:0]  redirect_addr;
  logic [4:0]  pc;
  logic        halted;
  logic [7:0]  retired_cnt;

  logic [15:0] mem [32];
  assign pm_data = mem[pm_addr];

  int unsigned pass_cnt = 0;
  int unsigned check_cnt = 0;

  // Reference model: running/holding/halted flags rather than a state code.
  logic        m_run, m_valid, m_halted;
  logic [4:0]  m_pc;
  logic [15:0] m_instr;
  logic [7:0]  m_cnt;

  fetch_sequencer #(.RESET_PC(5'd0), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pm_addr(pm_addr),
    .pm_data(pm_data), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .pc(pc), .halted(halted),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic load_plan_mem();
    for (int i = 0; i < 32; i++) mem[i] = 16'h0000;
    mem[0] = 16'b00001_010_000_00001;
    mem[1] = 16'b00001_011_001_00010;
    mem[2] = 16'b11111_000_000_00000;
  endtask

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_halted = 0; m_pc = 0; m_instr = 0; m_cnt = 0;
  endtask

  // Applies one cycle of inputs, advances the model, clocks the DUT.
  task automatic tick(input logic st, input logic rd, input logic rv, input logic [4:0] ra);
    start = st; instr_ready = rd; redirect_valid = rv; redirect_addr = ra;
    if (!m_run) begin
      if (st) begin m_run = 1; m_halted = 0; m_pc = 0; end
    end else if (!m_valid) begin
      if (rv) m_pc = ra;
      else begin m_instr = mem[m_pc]; m_valid = 1; end
    end else if (rv) begin
      m_valid = 0; m_pc = ra;
    end else if (rd) begin
      m_valid = 0;
      if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      if (m_instr[15:11] == 5'b11111) begin m_halted = 1; m_run = 0; end
      else m_pc = m_pc + 5'd1;
    end
    @(posedge clk); #1;
    start = 0; instr_ready = 0; redirect_valid = 0; redirect_addr = 0;
  endtask

  task automatic do_reset();
    reset_n = 0; model_reset();
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic test_reset();
    start = 0; instr_ready = 0; redirect_valid = 0; redirect_addr = 0;
    load_plan_mem();
    do_reset();
    check_cnt++;
    if ({instr_valid, instr, pc, halted, retired_cnt} !== 31'd0 || pm_addr !== 5'd0)
      $display("FAIL reset_state: got v=%0b instr=%h pc=%0d halted=%0b cnt=%0d, expected all zero",
               instr_valid, instr, pc, halted, retired_cnt);
    else pass_cnt++;
  endtask

  task automatic test_sequence();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h0A01; exp_seq[1] = 16'h0B22; exp_seq[2] = 16'hF800;
    tick(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(0, 1, 0, 0);
      check_cnt++;
      if (instr_valid !== 1'b1 || instr !== exp_seq[k])
        $display("FAIL seq_instr%0d: got v=%0b instr=%h, expected v=1 instr=%h", k, instr_valid, instr, exp_seq[k]);
      else pass_cnt++;
      tick(0, 1, 0, 0);
    end
    check_cnt++;
    if (halted !== 1'b1 || pc !== 5'd2 || retired_cnt !== 8'd3 || instr_valid !== 1'b0)
      $display("FAIL seq_halt: got halted=%0b pc=%0d cnt=%0d v=%0b, expected halted=1 pc=2 cnt=3 v=0",
               halted, pc, retired_cnt, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_halt_redirect_restart();
    tick(0, 1, 1, 5'd17);
    tick(0, 1, 1, 5'd9);
    check_cnt++;
    if (halted !== 1'b1 || pc !== 5'd2 || instr_valid !== 1'b0 || retired_cnt !== 8'd3)
      $display("FAIL halt_ignores_redirect: got halted=%0b pc=%0d v=%0b cnt=%0d, expected 1/2/0/3",
               halted, pc, instr_valid, retired_cnt);
    else pass_cnt++;
    tick(1, 0, 0, 0);
    check_cnt++;
    if (halted !== 1'b0 || pc !== 5'd0)
      $display("FAIL restart: got halted=%0b pc=%0d, expected halted=0 pc=0", halted, pc);
    else pass_cnt++;
    tick(0, 0, 0, 0);
    check_cnt++;
    if (instr_valid !== 1'b1 || instr !== 16'h0A01 || retired_cnt !== 8'd3)
      $display("FAIL restart_fetch: got v=%0b instr=%h cnt=%0d, expected v=1 instr=0a01 cnt=3",
               instr_valid, instr, retired_cnt);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    for (int k = 0; k < 5; k++) begin
      tick(0, 0, 0, 0);
      check_cnt++;
      if (instr_valid !== 1'b1 || instr !== 16'h0A01 || pc !== 5'd0 || retired_cnt !== 8'd3)
        $display("FAIL stall%0d: got v=%0b instr=%h pc=%0d cnt=%0d, expected v=1 instr=0a01 pc=0 cnt=3",
                 k, instr_valid, instr, pc, retired_cnt);
      else pass_cnt++;
    end
  endtask

  task automatic test_redirect_wrap();
    tick(0, 1, 1, 5'd31);
    check_cnt++;
    if (instr_valid !== 1'b0 || pc !== 5'd31 || pm_addr !== 5'd31 || retired_cnt !== 8'd3)
      $display("FAIL redirect_drop: got v=%0b pc=%0d addr=%0d cnt=%0d, expected v=0 pc=31 addr=31 cnt=3",
               instr_valid, pc, pm_addr, retired_cnt);
    else pass_cnt++;
    tick(0, 0, 0, 0);
    check_cnt++;
    if (instr_valid !== 1'b1 || instr !== 16'h0000)
      $display("FAIL redirect_fetch: got v=%0b instr=%h, expected v=1 instr=0000", instr_valid, instr);
    else pass_cnt++;
    tick(0, 1, 0, 0);
    check_cnt++;
    if (pc !== 5'd0 || retired_cnt !== 8'd4 || instr_valid !== 1'b0)
      $display("FAIL pc_wrap: got pc=%0d cnt=%0d v=%0b, expected pc=0 cnt=4 v=0", pc, retired_cnt, instr_valid);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    tick(0, 0, 0, 0);
    #2 reset_n = 0;
    #1;
    check_cnt++;
    if (instr_valid !== 1'b0 || instr !== 16'h0 || pc !== 5'd0 || halted !== 1'b0 || retired_cnt !== 8'd0)
      $display("FAIL async_reset: got v=%0b instr=%h pc=%0d halted=%0b cnt=%0d, expected all zero",
               instr_valid, instr, pc, halted, retired_cnt);
    else pass_cnt++;
    model_reset();
    @(posedge clk); #1;
    reset_n = 1;
    for (int k = 0; k < 4; k++) tick(0, 1, 0, 0);
    check_cnt++;
    if (instr_valid !== 1'b0 || pc !== 5'd0 || retired_cnt !== 8'd0)
      $display("FAIL idle_no_fetch: got v=%0b pc=%0d cnt=%0d, expected v=0 pc=0 cnt=0", instr_valid, pc, retired_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    int unsigned rounds = 0;
    while (m_cnt != 8'd255 && rounds < 200) begin
      tick(1, 1, 0, 0);
      for (int k = 0; k < 6; k++) tick(0, 1, 0, 0);
      rounds++;
    end
    check_cnt++;
    if (retired_cnt !== m_cnt || m_cnt !== 8'd255)
      $display("FAIL sat_reach: got cnt=%0d, expected 255 (model %0d, rounds %0d)", retired_cnt, m_cnt, rounds);
    else pass_cnt++;
    tick(1, 1, 0, 0);
    for (int k = 0; k < 6; k++) tick(0, 1, 0, 0);
    check_cnt++;
    if (retired_cnt !== 8'd255 || halted !== 1'b1)
      $display("FAIL sat_hold: got cnt=%0d halted=%0b, expected cnt=255 halted=1", retired_cnt, halted);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [30:0] got, exp_v;
    int unsigned errs = 0;
    for (int i = 0; i < 32; i++) begin
      mem[i] = 16'($urandom);
      if ($urandom_range(0, 7) == 0) mem[i][15:11] = 5'b11111;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 5) == 0), 5'($urandom));
      got   = {instr_valid, (instr_valid ? instr : 16'h0), pc, halted, retired_cnt};
      exp_v = {m_valid, (m_valid ? m_instr : 16'h0), m_pc, m_halted, m_cnt};
      check_cnt++;
      if (got !== exp_v || pm_addr !== m_pc) begin
        if (errs < 10)
          $display("FAIL random_cycle%0d: got v=%0b instr=%h pc=%0d halted=%0b cnt=%0d, expected v=%0b instr=%h pc=%0d halted=%0b cnt=%0d",
                   c, got[30], got[29:14], got[13:9], got[8], got[7:0],
                   exp_v[30], exp_v[29:14], exp_v[13:9], exp_v[8], exp_v[7:0]);
        errs++;
      end else pass_cnt++;
    end
  endtask

  initial begin
    reset_n = 1;
    test_reset();
    test_sequence();
    test_halt_redirect_restart();
    test_stall();
    test_redirect_wrap();
    test_async_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
